sc_ctrl: RTL and testbench



---
 rtl/sc_ctrl_if.sv | 30 +++
 rtl/sc_ctrl.sv | 158 +++++++++++++++
 tb/tb_sc_ctrl.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sc_ctrl_if.sv
// sc_ctrl_if: groups the sequencing commands, the counter feedback and the
// status outputs that pass between the test/sequence logic, the sc counter
// and the sc_ctrl stage. The master side drives commands and counter
// feedback. The slave side is the controller itself.
interface sc_ctrl_if #(
  parameter int ROUND_W = 8
) ();

  logic               start;
  logic               stop;
  logic [2:0]         cnt_in;
  logic               cnt_err;
  logic               ctr_rst;
  logic               busy;
  logic               round_done;
  logic [ROUND_W-1:0] rounds;
  logic               fault;
  logic [1:0]         fault_code;

  modport master (
    output start, stop, cnt_in, cnt_err,
    input  ctr_rst, busy, round_done, rounds, fault, fault_code
  );

  modport slave (
    input  start, stop, cnt_in, cnt_err,
    output ctr_rst, busy, round_done, rounds, fault, fault_code
  );

endinterface

// File: rtl/sc_ctrl.sv
// sc_ctrl: control/monitor stage for the 3-bit saturating counter sc.
// It runs a programmable number of rounds. In each round the counter counts
// up from 0 to MAX_CNT, dwells at saturation for HOLD_CYCLES cycles, and is
// then cleared for one cycle. Every count value is checked against the
// legal sequence. A counter error or an out-of-sequence value parks the
// controller in a sticky FAULT state, which only a new start leaves.
module sc_ctrl #(
  parameter int MAX_CNT     = 5,
  parameter int HOLD_CYCLES = 2,
  parameter int NUM_ROUNDS  = 4,
  parameter int ROUND_W     = 8
) (
  input logic     clk,
  input logic     rst_n,
  sc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    HOLD,
    CLEAR,
    FAULT
  } state_t;

  localparam logic [2:0]         MAX_VAL       = 3'(MAX_CNT);
  localparam logic [3:0]         HOLD_LOAD     = 4'(HOLD_CYCLES - 1);
  localparam logic [ROUND_W-1:0] ROUNDS_TARGET = ROUND_W'(NUM_ROUNDS);
  localparam logic [1:0]         CODE_NONE     = 2'b00;
  localparam logic [1:0]         CODE_ERR      = 2'b01;
  localparam logic [1:0]         CODE_SEQ      = 2'b10;

  state_t             state;
  state_t             state_nxt;
  logic               first_q;
  logic [2:0]         prev_q;
  logic [3:0]         hold_cnt;
  logic [3:0]         hold_cnt_nxt;
  logic [ROUND_W-1:0] rounds_q;
  logic [ROUND_W-1:0] rounds_nxt;
  logic [1:0]         code_q;
  logic [1:0]         code_nxt;

  logic [2:0]         expected;
  logic [ROUND_W-1:0] rounds_inc;

  // The first RUN cycle after entry must see 0. Every later cycle must see
  // the previous value plus one.
  assign expected   = first_q ? 3'd0 : prev_q + 3'd1;

  // The completed-round count sticks at all-ones instead of wrapping.
  assign rounds_inc = (&rounds_q) ? rounds_q : rounds_q + 1'b1;

  // State, dwell counter, round count and fault code registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= 4'd0;
      rounds_q <= '0;
      code_q   <= CODE_NONE;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      rounds_q <= rounds_nxt;
      code_q   <= code_nxt;
    end
  end

  // Sequence-tracking registers. first_q marks the first cycle spent in RUN
  // after arriving from any other state. prev_q delays the count input by
  // one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b1;
      prev_q  <= 3'd0;
    end else begin
      first_q <= (state != RUN);
      prev_q  <= bus.cnt_in;
    end
  end

  // Next-state logic. In the active states stop outranks any fault, and a
  // counter error outranks a sequence mismatch.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    rounds_nxt   = rounds_q;
    code_nxt     = code_q;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_nxt  = RUN;
          rounds_nxt = '0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (bus.cnt_err) begin
          state_nxt = FAULT;
          code_nxt  = CODE_ERR;
        end else if (bus.cnt_in != expected) begin
          state_nxt = FAULT;
          code_nxt  = CODE_SEQ;
        end else if (bus.cnt_in == MAX_VAL) begin
          state_nxt    = HOLD;
          hold_cnt_nxt = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (bus.cnt_err) begin
          state_nxt = FAULT;
          code_nxt  = CODE_ERR;
        end else if (bus.cnt_in != MAX_VAL) begin
          state_nxt = FAULT;
          code_nxt  = CODE_SEQ;
        end else if (hold_cnt == 4'd0) begin
          state_nxt = CLEAR;
        end else begin
          hold_cnt_nxt = hold_cnt - 4'd1;
        end
      end
      CLEAR: begin
        rounds_nxt = rounds_inc;
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (bus.cnt_err) begin
          state_nxt = FAULT;
          code_nxt  = CODE_ERR;
        end else if (rounds_inc == ROUNDS_TARGET) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RUN;
        end
      end
      FAULT: begin
        if (bus.start && !bus.stop) begin
          state_nxt  = RUN;
          code_nxt   = CODE_NONE;
          rounds_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.ctr_rst    = (state == IDLE) || (state == CLEAR) || (state == FAULT);
  assign bus.busy       = (state == RUN) || (state == HOLD) || (state == CLEAR);
  assign bus.round_done = (state == CLEAR);
  assign bus.rounds     = rounds_q;
  assign bus.fault      = (state == FAULT);
  assign bus.fault_code = code_q;

endmodule

// File: tb/tb_sc_ctrl.sv
// tb_sc_ctrl: randomized and directed stimulus for sc_ctrl. A saturating
// counter model supplies cnt_in, and faults can be injected into it. All
// outputs are compared against a round-position reference model.
module tb_sc_ctrl;

  localparam int MAX_CNT     = 5;
  localparam int HOLD_CYCLES = 2;
  localparam int NUM_ROUNDS  = 4;
  localparam int ROUND_W     = 8;
  localparam int CLR_POS     = MAX_CNT + HOLD_CYCLES + 1;
  localparam int ROUND_MAX   = (1 << ROUND_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  sc_ctrl_if #(.ROUND_W(ROUND_W)) bus ();

  sc_ctrl #(
    .MAX_CNT    (MAX_CNT),
    .HOLD_CYCLES(HOLD_CYCLES),
    .NUM_ROUNDS (NUM_ROUNDS),
    .ROUND_W    (ROUND_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rd_seen = 0;

  // The reference model tracks only the mode and the position within the
  // current round:
  //   positions 0..MAX_CNT            are counting,
  //   positions MAX_CNT+1..CLR_POS-1  are the dwell,
  //   position  CLR_POS               is the clear cycle.
  typedef enum {M_IDLE, M_ACTIVE, M_FAULT} mode_t;
  mode_t m_mode;
  int    m_pos;
  int    m_rounds;
  int    m_code;
  int    sc_cnt;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_clear();
    return (m_mode == M_ACTIVE) && (m_pos == CLR_POS);
  endfunction

  function automatic int exp_ctr_rst();
    return (m_mode != M_ACTIVE || m_clear()) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_pos    = 0;
    m_rounds = 0;
    m_code   = 0;
    sc_cnt   = 0;
  endtask

  task automatic check_all();
    checkOutput("ctr_rst",    int'(bus.ctr_rst),    exp_ctr_rst());
    checkOutput("busy",       int'(bus.busy),       (m_mode == M_ACTIVE) ? 1 : 0);
    checkOutput("round_done", int'(bus.round_done), m_clear() ? 1 : 0);
    checkOutput("rounds",     int'(bus.rounds),     m_rounds);
    checkOutput("fault",      int'(bus.fault),      (m_mode == M_FAULT) ? 1 : 0);
    checkOutput("fault_code", int'(bus.fault_code), m_code);
  endtask

  task automatic model_step(input bit s, input bit p, input bit e, input int c);
    bit is_run;
    bit is_hold;
    bit is_clr;
    case (m_mode)
      M_IDLE: begin
        if (s && !p) begin
          m_mode   = M_ACTIVE;
          m_pos    = 0;
          m_rounds = 0;
        end
      end
      M_ACTIVE: begin
        is_clr  = (m_pos == CLR_POS);
        is_run  = (m_pos <= MAX_CNT);
        is_hold = !is_run && !is_clr;
        if (is_clr) m_rounds = (m_rounds == ROUND_MAX) ? m_rounds : m_rounds + 1;
        if (p) begin
          m_mode = M_IDLE;
        end else if (e) begin
          m_mode = M_FAULT;
          m_code = 1;
        end else if ((is_run && c != m_pos) || (is_hold && c != MAX_CNT)) begin
          m_mode = M_FAULT;
          m_code = 2;
        end else if (is_clr) begin
          if (m_rounds == NUM_ROUNDS) m_mode = M_IDLE;
          else m_pos = 0;
        end else begin
          m_pos++;
        end
      end
      default: begin
        if (s && !p) begin
          m_mode   = M_ACTIVE;
          m_pos    = 0;
          m_rounds = 0;
          m_code   = 0;
        end
      end
    endcase
  endtask

  // One clock cycle: check the outputs at the falling edge, drive the inputs,
  // then advance the counter model and the reference model at the rising edge.
  task automatic applyStimulus(input bit s, input bit p, input bit e,
                               input bit ov, input int ov_val);
    int c;
    int clr;
    @(negedge clk);
    check_all();
    if (bus.round_done) rd_seen++;
    c           = ov ? (ov_val & 7) : sc_cnt;
    bus.start   = s;
    bus.stop    = p;
    bus.cnt_err = e;
    bus.cnt_in  = 3'(c);
    clr         = exp_ctr_rst();
    @(posedge clk);
    model_step(s, p, e, c);
    if (clr != 0) sc_cnt = 0;
    else if (sc_cnt < MAX_CNT) sc_cnt++;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.cnt_in  = 3'd0;
    bus.cnt_err = 1'b0;
    model_reset();

    // Reset and its output values.
    #2 rst_n = 1'b0;
    #1 check_all();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Four clean rounds from a single start pulse.
    rd_seen = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(40);
    checkOutput("round_done_count", rd_seen, NUM_ROUNDS);

    // The counter skips from 2 to 4 in round 1, giving a sequence fault.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4);
    idle_cycles(3);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(40);

    // cnt_err and a bad count together in HOLD: the error code wins.
    // Start with stop set is then ignored while in FAULT.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(6);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 3);
    idle_cycles(2);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);
    idle_cycles(2);

    // Restart from FAULT, then stop in round 2: rounds holds at 1.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(12);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0);
    idle_cycles(3);

    // start together with stop in IDLE, then start pulses while busy.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0);
    idle_cycles(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(40);

    // Asynchronous reset between clock edges during the round-2 HOLD.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0);
    idle_cycles(16);
    checkOutput("pre_reset_rounds", int'(bus.rounds), 1);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Randomized traffic with sporadic commands and injected counter faults.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom % 6) == 0, ($urandom % 80) == 0,
                    ($urandom % 250) == 0, ($urandom % 120) == 0,
                    int'($urandom % 8));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
